// File: rtl/la_deglitch.sv
// Synchronizes an asynchronous level and accepts each change only after it stays stable for cfg_cnt+2 cycles.
// Latency: SYNC+2+cfg_cnt clocks from a to z. No backpressure; rise/fall/glitch are one-cycle event pulses.
module la_deglitch #(
    parameter     PROP = "DEFAULT",
    parameter int SYNC = 2,
    parameter int CW   = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          a,
    input  logic [CW-1:0] cfg_cnt,
    output logic          z,
    output logic          rise,
    output logic          fall,
    output logic          glitch,
    output logic          busy
);

    typedef enum logic [1:0] {ST0, CHK1, ST1, CHK0} state_t;

    logic [SYNC-1:0] sync;
    logic            s;
    state_t          state, state_nxt;
    logic [CW-1:0]   cnt, cnt_nxt;
    logic            z_nxt, rise_nxt, fall_nxt, glitch_nxt, busy_nxt;

    assign s = sync[SYNC-1];

    always_ff @(posedge clk) begin
        if (reset) begin
            sync   <= '0;
            state  <= ST0;
            cnt    <= '0;
            z      <= 1'b0;
            rise   <= 1'b0;
            fall   <= 1'b0;
            glitch <= 1'b0;
            busy   <= 1'b0;
        end else begin
            sync   <= {sync[SYNC-2:0], a};
            state  <= state_nxt;
            cnt    <= cnt_nxt;
            z      <= z_nxt;
            rise   <= rise_nxt;
            fall   <= fall_nxt;
            glitch <= glitch_nxt;
            busy   <= busy_nxt;
        end
    end

    // cnt only advances while below cfg_cnt, so it can never wrap
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            ST0: begin
                cnt_nxt = '0;
                if (s) state_nxt = CHK1;
            end
            CHK1: begin
                if (!s) begin
                    state_nxt = ST0;
                    cnt_nxt   = '0;
                end else if (cnt >= cfg_cnt) begin
                    state_nxt = ST1;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            ST1: begin
                cnt_nxt = '0;
                if (!s) state_nxt = CHK0;
            end
            CHK0: begin
                if (s) begin
                    state_nxt = ST1;
                    cnt_nxt   = '0;
                end else if (cnt >= cfg_cnt) begin
                    state_nxt = ST0;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            default: begin
                state_nxt = ST0;
                cnt_nxt   = '0;
            end
        endcase
    end

    // Outputs are derived from the upcoming state so they register alongside it
    always_comb begin
        z_nxt      = (state_nxt == ST1) || (state_nxt == CHK0);
        busy_nxt   = (state_nxt == CHK1) || (state_nxt == CHK0);
        rise_nxt   = (state == CHK1) && (state_nxt == ST1);
        fall_nxt   = (state == CHK0) && (state_nxt == ST0);
        glitch_nxt = ((state == CHK1) && (state_nxt == ST0)) ||
                     ((state == CHK0) && (state_nxt == ST1));
    end

endmodule

// File: tb/tb_la_deglitch.sv
// Directed and model-based checks of la_deglitch with SYNC=2, CW=8.
module tb_la_deglitch;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       a = 1'b0;
    logic [7:0] cfg_cnt = 8'd0;
    logic       z, rise, fall, glitch, busy;

    int checks = 0;
    int errors = 0;

    // reference model state
    logic m_s0, m_s1, m_z, m_chk;
    int   m_cnt;
    logic e_rise, e_fall, e_glitch;

    la_deglitch #(.PROP("DEFAULT"), .SYNC(2), .CW(8)) dut (
        .clk(clk), .reset(reset), .a(a), .cfg_cnt(cfg_cnt),
        .z(z), .rise(rise), .fall(fall), .glitch(glitch), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input logic a_val);
        reset = 1'b1;
        a = a_val;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic settle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic test_reset;
        a = 1'b1;
        reset = 1'b1;
        tick();
        checks++;
        if ({z, rise, fall, glitch, busy} !== 5'b0) begin
            errors++;
            $display("FAIL reset_outputs: got %b, expected 00000", {z, rise, fall, glitch, busy});
        end
        reset = 1'b0;
    endtask

    task automatic test_rise_latency;
        cfg_cnt = 8'd3;
        do_reset(1'b0);
        settle(4);
        a = 1'b1;
        for (int k = 1; k <= 9; k++) begin
            tick();
            checks++;
            if (z !== (k >= 7) || rise !== (k == 7) || busy !== (k >= 3 && k <= 6) || glitch !== 1'b0) begin
                errors++;
                $display("FAIL rise_latency edge %0d: z/rise/busy/glitch=%b%b%b%b, expected %b%b%b0",
                         k, z, rise, busy, glitch, (k >= 7), (k == 7), (k >= 3 && k <= 6));
            end
        end
    endtask

    task automatic test_glitch(input logic base);
        int gcnt, bad_z;
        cfg_cnt = 8'd3;
        do_reset(base);
        settle(12);
        gcnt = 0;
        bad_z = 0;
        a = ~base;
        for (int k = 0; k < 3; k++) begin
            tick();
            gcnt += glitch;
            if (z !== base) bad_z++;
        end
        a = base;
        for (int k = 0; k < 10; k++) begin
            tick();
            gcnt += glitch;
            if (z !== base || rise || fall) bad_z++;
        end
        checks++;
        if (bad_z != 0) begin
            errors++;
            $display("FAIL glitch_z base=%b: z changed or edge pulsed %0d times, expected 0", base, bad_z);
        end
        checks++;
        if (gcnt != 1) begin
            errors++;
            $display("FAIL glitch_count base=%b: got %0d pulses, expected 1", base, gcnt);
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL glitch_busy base=%b: got %b, expected 0", base, busy);
        end
    endtask

    task automatic test_cfg0_toggle;
        logic ahist [0:63];
        logic zprev, ez;
        cfg_cnt = 8'd0;
        do_reset(1'b0);
        settle(6);
        zprev = 1'b0;
        for (int k = 0; k < 48; k++) begin
            a = ((k / 4) % 2 == 1);
            ahist[k] = a;
            tick();
            // value applied before edge j shows on z after edge j+3
            ez = (k >= 3) ? ahist[k-3] : 1'b0;
            checks++;
            if (z !== ez || rise !== (ez & ~zprev) || fall !== (~ez & zprev) || glitch !== 1'b0) begin
                errors++;
                $display("FAIL cfg0_toggle step %0d: z/rise/fall/glitch=%b%b%b%b, expected %b%b%b0",
                         k, z, rise, fall, glitch, ez, ez & ~zprev, ~ez & zprev);
            end
            zprev = ez;
        end
    endtask

    task automatic test_long_count;
        cfg_cnt = 8'd255;
        do_reset(1'b0);
        settle(4);
        a = 1'b1;
        settle(258);
        checks++;
        if (z !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL long_before: z=%b busy=%b, expected z=0 busy=1", z, busy);
        end
        tick();
        checks++;
        if (z !== 1'b1 || rise !== 1'b1) begin
            errors++;
            $display("FAIL long_rise: z=%b rise=%b, expected 1 1", z, rise);
        end
        a = 1'b0;
        settle(53);
        checks++;
        if (z !== 1'b1 || busy !== 1'b1 || fall !== 1'b0) begin
            errors++;
            $display("FAIL long_chk0: z=%b busy=%b fall=%b, expected 1 1 0", z, busy, fall);
        end
        cfg_cnt = 8'd10;
        tick();
        checks++;
        if (z !== 1'b0 || fall !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL long_cfg_drop: z=%b fall=%b busy=%b, expected 0 1 0", z, fall, busy);
        end
    endtask

    task automatic test_reset_mid_check;
        cfg_cnt = 8'd3;
        do_reset(1'b0);
        settle(4);
        a = 1'b1;
        settle(4);
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL midreset_pre: busy=%b, expected 1", busy);
        end
        reset = 1'b1;
        tick();
        checks++;
        if ({z, rise, fall, glitch, busy} !== 5'b0) begin
            errors++;
            $display("FAIL midreset_outputs: got %b, expected 00000", {z, rise, fall, glitch, busy});
        end
        reset = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            tick();
            checks++;
            if (z !== (k >= 7) || rise !== (k == 7) || glitch !== 1'b0) begin
                errors++;
                $display("FAIL midreset_rerise edge %0d: z/rise/glitch=%b%b%b, expected %b%b0",
                         k, z, rise, glitch, (k >= 7), (k == 7));
            end
        end
    endtask

    task automatic test_random;
        logic s;
        logic last_edge, have_edge;
        cfg_cnt = 8'd2;
        do_reset(1'b0);
        m_s0 = 0; m_s1 = 0; m_z = 0; m_chk = 0; m_cnt = 0;
        have_edge = 1'b0;
        last_edge = 1'b0;
        for (int k = 0; k < 3000; k++) begin
            if ($urandom_range(0, 5) == 0) a = ~a;
            if ($urandom_range(0, 40) == 0) cfg_cnt = 8'($urandom_range(0, 6));
            s = m_s1;
            m_s1 = m_s0;
            m_s0 = a;
            e_rise = 0; e_fall = 0; e_glitch = 0;
            if (!m_chk) begin
                if (s != m_z) begin
                    m_chk = 1;
                    m_cnt = 0;
                end
            end else if (s == m_z) begin
                m_chk = 0;
                e_glitch = 1;
            end else if (m_cnt >= int'(cfg_cnt)) begin
                m_chk = 0;
                m_z = s;
                e_rise = s;
                e_fall = ~s;
            end else begin
                m_cnt++;
            end
            tick();
            checks++;
            if ({z, rise, fall, glitch, busy} !== {m_z, e_rise, e_fall, e_glitch, m_chk}) begin
                errors++;
                $display("FAIL random step %0d: z/rise/fall/glitch/busy=%b, expected %b",
                         k, {z, rise, fall, glitch, busy}, {m_z, e_rise, e_fall, e_glitch, m_chk});
            end
            if (rise || fall) begin
                checks++;
                if ((rise && fall) || glitch || (have_edge && rise == last_edge)) begin
                    errors++;
                    $display("FAIL random_alternate step %0d: rise=%b fall=%b glitch=%b prev_rise=%b",
                             k, rise, fall, glitch, last_edge);
                end
                have_edge = 1'b1;
                last_edge = rise;
            end
        end
    endtask

    initial begin
        test_reset();
        test_rise_latency();
        test_glitch(1'b0);
        test_glitch(1'b1);
        test_cfg0_toggle();
        test_long_count();
        test_reset_mid_check();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
